writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 35 +++
 rtl/writeback_stage_load_extract.sv | 37 +++
 rtl/writeback_stage.sv | 125 ++++++++++++
 tb/tb_writeback_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings and defaults for the writeback stage: result-select and
// load-type codes plus the misaligned-load rule.
package writeback_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  // Reserved load types fall into the word case.
  function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (lt)
      LD_B, LD_BU: mis = 1'b0;
      LD_H, LD_HU: mis = off[0];
      default:     mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Selects the addressed byte/half of a little-endian memory word and
// sign- or zero-extends it to the datapath width.
module writeback_stage_load_extract
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        byte_off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (load_type_i)
      LD_B:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result selection, load extraction,
// register-file write port, same-cycle bypass and retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              reset,
  input  logic              clk,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [REG_AW-1:0] in_dest_reg,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              align_err,
  output logic [31:0]       retire_count
);

  logic              valid_q,     valid_d;
  logic              reg_write_q, reg_write_d;
  wb_sel_e           wb_sel_q,    wb_sel_d;
  logic [2:0]        load_type_q, load_type_d;
  logic [1:0]        byte_off_q,  byte_off_d;
  logic [DATA_W-1:0] alu_q,       alu_d;
  logic [DATA_W-1:0] mem_q,       mem_d;
  logic [DATA_W-1:0] pc_q,        pc_d;
  logic [REG_AW-1:0] dest_q,      dest_d;
  logic [31:0]       retire_q,    retire_d;

  logic [DATA_W-1:0] load_data;

  // Flush only kills valid; the payload is left as-is since nothing reads it.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    load_type_d = load_type_q;
    byte_off_d  = byte_off_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    retire_d    = retire_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      reg_write_d = in_reg_write;
      wb_sel_d    = wb_sel_e'(in_wb_sel);
      load_type_d = in_load_type;
      byte_off_d  = in_byte_off;
      alu_d       = in_alu_result;
      mem_d       = in_mem_rdata;
      pc_d        = in_pc_plus4;
      dest_d      = in_dest_reg;
      if (in_valid) retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= WB_ALU;
      load_type_q <= '0;
      byte_off_q  <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc_q        <= '0;
      dest_q      <= '0;
      retire_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      load_type_q <= load_type_d;
      byte_off_q  <= byte_off_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      pc_q        <= pc_d;
      dest_q      <= dest_d;
      retire_q    <= retire_d;
    end
  end

  writeback_stage_load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .word_i      (mem_q),
    .load_type_i (load_type_q),
    .byte_off_i  (byte_off_q),
    .data_o      (load_data)
  );

  always_comb begin
    align_err = valid_q & (wb_sel_q == WB_MEM) & load_misaligned(load_type_q, byte_off_q);
    rf_write  = valid_q & reg_write_q & (dest_q != '0) & ~align_err;
    rf_waddr  = dest_q;
    case (wb_sel_q)
      WB_ALU:  rf_wdata = alu_q;
      WB_MEM:  rf_wdata = load_data;
      WB_LINK: rf_wdata = pc_q;
      default: rf_wdata = '0;
    endcase
  end

  assign fwd_valid    = rf_write;
  assign fwd_reg      = rf_waddr;
  assign fwd_data     = rf_wdata;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: a transaction-level model of the
// WB slot is checked every cycle, plus literal checks of key scenarios.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_reg_write;
  logic [1:0]  in_wb_sel, in_byte_off;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
  logic [4:0]  in_dest_reg;
  logic        rf_write, fwd_valid, align_err;
  logic [4:0]  rf_waddr, fwd_reg;
  logic [31:0] rf_wdata, fwd_data, retire_count;

  writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .reset(reset), .clk(clk), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_dest_reg(in_dest_reg),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .align_err(align_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid, rw;
    int unsigned sel, lt, off, dest;
    bit [31:0]   alu, mem, pc;
  } instr_t;

  instr_t      m_wb;
  bit          m_clean;
  bit [31:0]   m_count;
  bit          run = 1'b0;
  int unsigned nvec = 0, nbad = 0;

  // Model: one instruction slot, a "nothing captured since reset" flag, a counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wb.valid <= 1'b0;
      m_clean    <= 1'b1;
      m_count    <= 32'd0;
    end else if (flush) begin
      m_wb.valid <= 1'b0;
    end else if (!stall) begin
      m_wb <= '{valid: in_valid, rw: in_reg_write, sel: int'(in_wb_sel),
                lt: int'(in_load_type), off: int'(in_byte_off),
                dest: int'(in_dest_reg), alu: in_alu_result,
                mem: in_mem_rdata, pc: in_pc_plus4};
      m_clean <= 1'b0;
      if (in_valid) m_count <= m_count + 32'd1;
    end
  end

  function automatic bit exp_err(instr_t r);
    if (!r.valid || r.sel != 1) return 1'b0;
    if (r.lt == 1 || r.lt == 2) return 1'b0;
    if (r.lt == 3 || r.lt == 4) return (r.off % 2) != 0;
    return r.off != 0;
  endfunction

  function automatic bit exp_we(instr_t r);
    return r.valid && r.rw && r.dest != 0 && !exp_err(r);
  endfunction

  function automatic bit [31:0] exp_load(instr_t r);
    bit [31:0] b, h;
    b = (r.mem >> (8 * r.off)) & 32'hFF;
    h = (r.mem >> (16 * (r.off / 2))) & 32'hFFFF;
    case (r.lt)
      1:       return (b < 128) ? b : b - 32'd256;
      2:       return b;
      3:       return (h < 32768) ? h : h - 32'd65536;
      4:       return h;
      default: return r.mem;
    endcase
  endfunction

  function automatic bit [31:0] exp_data(instr_t r);
    case (r.sel)
      0:       return r.alu;
      1:       return exp_load(r);
      2:       return r.pc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("rf_write", 32'(rf_write), 32'(exp_we(m_wb)));
      chk("fwd_valid", 32'(fwd_valid), 32'(exp_we(m_wb)));
      chk("align_err", 32'(align_err), 32'(exp_err(m_wb)));
      chk("retire_count", retire_count, m_count);
      if (m_clean) begin
        chk("rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rf_wdata", rf_wdata, 32'd0);
        chk("fwd_reg", 32'(fwd_reg), 32'd0);
        chk("fwd_data", fwd_data, 32'd0);
      end else if (m_wb.valid) begin
        chk("rf_waddr", 32'(rf_waddr), m_wb.dest);
        chk("rf_wdata", rf_wdata, exp_data(m_wb));
        chk("fwd_reg", 32'(fwd_reg), m_wb.dest);
        chk("fwd_data", fwd_data, exp_data(m_wb));
      end
    end
  end

  function automatic instr_t mk(bit v, bit rw, int unsigned sel, int unsigned lt,
                                int unsigned off, bit [31:0] alu, bit [31:0] mem,
                                bit [31:0] pc, int unsigned dest);
    instr_t r;
    r = '{valid: v, rw: rw, sel: sel, lt: lt, off: off, dest: dest, alu: alu, mem: mem, pc: pc};
    return r;
  endfunction

  // Inputs change two units after a falling edge; returns just after the next one.
  task automatic drive(input instr_t r, input bit st, input bit fl);
    in_valid      = r.valid;
    in_reg_write  = r.rw;
    in_wb_sel     = 2'(r.sel);
    in_load_type  = 3'(r.lt);
    in_byte_off   = 2'(r.off);
    in_alu_result = r.alu;
    in_mem_rdata  = r.mem;
    in_pc_plus4   = r.pc;
    in_dest_reg   = 5'(r.dest);
    stall         = st;
    flush         = fl;
    @(negedge clk);
    #2;
  endtask

  function automatic instr_t rnd();
    return mk($urandom_range(9) != 0, $urandom_range(7) != 0, $urandom_range(3),
              $urandom_range(7), $urandom_range(3), $urandom, $urandom, $urandom,
              ($urandom_range(7) == 0) ? 0 : $urandom_range(31));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_rf_write"}, 32'(rf_write), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, "_fwd_data"}, fwd_data, 32'd0);
    chk({tag, "_align_err"}, 32'(align_err), 32'd0);
    chk({tag, "_retire"}, retire_count, 32'd0);
  endtask

  instr_t idle;

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(idle, 0, 0);
    run = 1'b1;
    drive(idle, 0, 0);
    chk_zero("in_reset");
    reset = 1'b0;
    drive(idle, 0, 0);
    chk_zero("after_reset");

    drive(mk(1, 1, 0, 0, 0, 32'h12345678, 0, 0, 8), 0, 0);
    chk("alu_write", 32'(rf_write), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd8);
    chk("alu_wdata", rf_wdata, 32'h12345678);
    chk("alu_retire", retire_count, 32'd1);

    drive(mk(1, 1, 1, 1, 3, 0, 32'h80FF7F01, 0, 3), 0, 0);
    chk("lb_wdata", rf_wdata, 32'hFFFFFF80);
    drive(mk(1, 1, 1, 2, 3, 0, 32'h80FF7F01, 0, 3), 0, 0);
    chk("lbu_wdata", rf_wdata, 32'h00000080);
    drive(mk(1, 1, 1, 3, 2, 0, 32'h80FF7F01, 0, 3), 0, 0);
    chk("lh_wdata", rf_wdata, 32'hFFFF80FF);

    drive(mk(1, 1, 1, 0, 2, 0, 32'hDEADBEEF, 0, 5), 0, 0);
    chk("lw_mis_err", 32'(align_err), 32'd1);
    chk("lw_mis_write", 32'(rf_write), 32'd0);
    drive(mk(1, 1, 1, 4, 1, 0, 32'hDEADBEEF, 0, 5), 0, 0);
    chk("lhu_mis_err", 32'(align_err), 32'd1);

    drive(mk(1, 1, 2, 0, 0, 32'h11111111, 0, 32'h00400010, 31), 0, 0);
    chk("link_wdata", rf_wdata, 32'h00400010);
    chk("link_waddr", 32'(rf_waddr), 32'd31);
    drive(mk(1, 1, 0, 0, 0, 32'h22222222, 0, 0, 0), 0, 0);
    chk("x0_write", 32'(rf_write), 32'd0);

    drive(mk(1, 1, 0, 0, 0, 32'hCAFEF00D, 0, 0, 12), 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      drive(rnd(), 1, 0);
      chk("stall_write", 32'(rf_write), 32'd1);
      chk("stall_waddr", 32'(rf_waddr), 32'd12);
      chk("stall_wdata", rf_wdata, 32'hCAFEF00D);
      chk("stall_retire", retire_count, 32'd9);
    end
    drive(rnd(), 1, 1);
    chk("stall_flush_write", 32'(rf_write), 32'd0);
    chk("stall_flush_retire", retire_count, 32'd9);

    drive(mk(1, 1, 0, 0, 0, 32'h55AA55AA, 0, 0, 7), 0, 0);
    drive(rnd(), 1, 0);
    chk("pre_reset_write", 32'(rf_write), 32'd1);
    reset = 1'b1;
    #1;
    chk_zero("mid_stall_reset");
    drive(rnd(), 1, 0);
    reset = 1'b0;
    drive(idle, 0, 0);
    chk_zero("post_stall_reset");

    for (int unsigned i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) == 0);
      drive(rnd(), $urandom_range(4) == 0, $urandom_range(9) == 0);
    end
    reset = 1'b0;
    drive(idle, 0, 0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
